// File: rtl/bip_uart_host.sv
// Host side of the BIP-over-UART link: sends each 16-bit instruction as two UART bytes
// and collects the 4-byte ACC/PC result frame. Optional response timeout: BIP_HOST_TIMEOUT_EN.
module bip_uart_host #(
  parameter int DBIT      = 8,
  parameter int TO_CYCLES = 1_000_000,
  parameter int TO_W      = 20
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            cmd_valid,
  input  logic [15:0]     cmd_instr,
  output logic            cmd_ready,
  input  logic            tx_full,
  output logic            wr_uart,
  output logic [DBIT-1:0] w_data,
  input  logic            rx_empty,
  input  logic [DBIT-1:0] r_data,
  output logic            rd_uart,
  output logic            rsp_valid,
  output logic [15:0]     rsp_acc,
  output logic [10:0]     rsp_pc,
  output logic            rsp_err
);

  typedef enum logic [2:0] {IDLE, TX_LO, TX_HI, RX, DONE} state_t;

  localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(TO_CYCLES);

  state_t      state, state_d;
  logic [15:0] instr;
  logic [1:0]  cnt;
  logic        rd_gap;
  logic [7:0]  acc_lo, acc_hi, pc_lo;
  logic        to_hit;
  logic        wr_en, rd_en, err_en;

  // NOTE: the FIFO strobes are decoded combinationally from the current tx_full/rx_empty,
  // so a strobe can never fire against a flag that changed since the last edge.
  assign cmd_ready = (state == IDLE);
  assign rsp_valid = (state == DONE);
  assign wr_uart   = wr_en;
  assign rd_uart   = rd_en;
  assign rsp_err   = err_en;
  assign w_data    = (state == TX_HI) ? instr[15:8] : instr[7:0];

`ifdef BIP_HOST_TIMEOUT_EN
  logic [TO_W-1:0] to_cnt;

  // Counts idle cycles in RX; any captured byte or leaving RX restarts it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      to_cnt <= '0;
    end else if (state != RX || rd_en) begin
      to_cnt <= '0;
    end else begin
      to_cnt <= to_cnt + TO_W'(1);
    end
  end

  assign to_hit = (state == RX) && (to_cnt == TO_LIMIT);
`else
  logic unused_to;
  assign unused_to = ^TO_LIMIT;
  assign to_hit    = 1'b0;
`endif

  // NOTE: every output of this block gets a default first so no path can infer a latch.
  always_comb begin
    state_d = state;
    wr_en   = 1'b0;
    rd_en   = 1'b0;
    err_en  = 1'b0;
    case (state)
      IDLE:  if (cmd_valid) state_d = TX_LO;
      TX_LO: if (!tx_full) begin
               wr_en   = 1'b1;
               state_d = TX_HI;
             end
      TX_HI: if (!tx_full) begin
               wr_en   = 1'b1;
               state_d = RX;
             end
      RX: begin
        // rd_gap leaves one cycle between pops for the FIFO empty flag to settle.
        if (!rx_empty && !rd_gap) begin
          rd_en = 1'b1;
          if (cnt == 2'd3) state_d = DONE;
        end else if (to_hit) begin
          err_en  = 1'b1;
          state_d = IDLE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      instr   <= '0;
      cnt     <= '0;
      rd_gap  <= 1'b0;
      acc_lo  <= '0;
      acc_hi  <= '0;
      pc_lo   <= '0;
      rsp_acc <= '0;
      rsp_pc  <= '0;
    end else begin
      state  <= state_d;
      rd_gap <= rd_en;
      if (state == IDLE && cmd_valid) instr <= cmd_instr;
      if (state == TX_HI && wr_en) cnt <= '0;
      if (rd_en) begin
        cnt <= cnt + 2'd1;
        case (cnt)
          2'd0: acc_lo <= r_data;
          2'd1: acc_hi <= r_data;
          2'd2: pc_lo  <= r_data;
          default: begin
            // Last byte: publish the whole frame so it is valid during DONE.
            rsp_acc <= {acc_hi, acc_lo};
            rsp_pc  <= {r_data[2:0], pc_lo};
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_bip_uart_host.sv
// Scoreboard bench for bip_uart_host: models the UART FIFOs, queues expected bytes/frames,
// and a negedge monitor compares every DUT strobe against them.
`timescale 1ns/1ps
module tb_bip_uart_host;

  localparam int PERIOD = 10;

  typedef struct packed {
    logic [15:0] acc;
    logic [10:0] pc;
  } rsp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        cmd_valid = 1'b0;
  logic [15:0] cmd_instr = '0;
  logic        tx_full = 1'b0;
  logic        rx_empty = 1'b1;
  logic [7:0]  r_data = '0;
  logic        cmd_ready, wr_uart, rd_uart, rsp_valid, rsp_err;
  logic [7:0]  w_data;
  logic [15:0] rsp_acc;
  logic [10:0] rsp_pc;

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0] rx_q[$];
  logic [7:0] exp_tx[$];
  rsp_t       exp_rsp[$];

  int  wr_cnt = 0, rd_cnt = 0, popped = 0, err_cnt = 0, exp_err = 0;
  bit  prev_rd = 1'b0;
  time wr_time = 0, err_time = 0;
  logic [15:0] last_acc = '0;
  logic [10:0] last_pc = '0;

  always #(PERIOD / 2) clk = ~clk;

  bip_uart_host #(.DBIT(8), .TO_CYCLES(100), .TO_W(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .cmd_valid (cmd_valid),
    .cmd_instr (cmd_instr),
    .cmd_ready (cmd_ready),
    .tx_full   (tx_full),
    .wr_uart   (wr_uart),
    .w_data    (w_data),
    .rx_empty  (rx_empty),
    .r_data    (r_data),
    .rd_uart   (rd_uart),
    .rsp_valid (rsp_valid),
    .rsp_acc   (rsp_acc),
    .rsp_pc    (rsp_pc),
    .rsp_err   (rsp_err)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Show-ahead rx FIFO: applies pops seen by the monitor, then presents the head byte.
  always @(posedge clk) begin
    #1;
    if (popped != rd_cnt) begin
      if (rx_q.size() > 0) void'(rx_q.pop_front());
      popped = rd_cnt;
    end
    rx_empty = (rx_q.size() == 0);
    r_data   = rx_empty ? 8'h00 : rx_q[0];
  end

  always @(negedge clk) begin
    if (wr_uart) begin
      check("wr_while_tx_full", tx_full, 1'b0);
      check("wr_expected", exp_tx.size() > 0, 1'b1);
      if (exp_tx.size() > 0) check("w_data", w_data, exp_tx.pop_front());
      wr_cnt++;
      wr_time = $time;
    end
    if (rd_uart) begin
      check("rd_while_rx_empty", rx_empty, 1'b0);
      check("rd_back_to_back", prev_rd, 1'b0);
      rd_cnt++;
    end
    prev_rd = rd_uart;
    if (rsp_valid) begin
      check("rsp_expected", exp_rsp.size() > 0, 1'b1);
      if (exp_rsp.size() > 0) begin
        rsp_t e;
        e = exp_rsp.pop_front();
        check("rsp_acc", rsp_acc, e.acc);
        check("rsp_pc", rsp_pc, e.pc);
        check("rsp_err_with_valid", rsp_err, 1'b0);
      end
    end
    if (rsp_err) begin
      check("rsp_err_expected", err_cnt < exp_err, 1'b1);
      err_cnt++;
      err_time = $time;
    end
  end

  task automatic wait_ready();
    @(negedge clk);
    for (int i = 0; i < 200 && !cmd_ready; i++) @(negedge clk);
    check("cmd_ready_wait", cmd_ready, 1'b1);
  endtask

  task automatic wait_writes(input int target);
    for (int i = 0; i < 100 && wr_cnt < target; i++) @(negedge clk);
    check("wr_wait", wr_cnt, target);
  endtask

  task automatic issue(input logic [15:0] instr, input bit full);
    @(posedge clk); #1;
    cmd_valid = 1'b1;
    cmd_instr = instr;
    tx_full   = full;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    @(negedge clk);
    check("cmd_ready_busy", cmd_ready, 1'b0);
  endtask

  // One full transaction; expected frame computed from wire bytes with plain arithmetic.
  task automatic txn(input logic [15:0] instr, input logic [31:0] bytes, input int gap,
                     input int stall, input bit poke);
    logic [7:0] b [4];
    int   wr0, rd0;
    rsp_t e;
    for (int k = 0; k < 4; k++) b[k] = bytes[8*k +: 8];
    e.acc = 16'(int'(b[1]) * 256 + int'(b[0]));
    e.pc  = 11'((int'(b[3]) * 256 + int'(b[2])) % 2048);
    wait_ready();
    wr0 = wr_cnt;
    rd0 = rd_cnt;
    exp_tx.push_back(instr[7:0]);
    exp_tx.push_back(instr[15:8]);
    exp_rsp.push_back(e);
    issue(instr, stall > 0);
    if (gap == 0) for (int k = 0; k < 4; k++) rx_q.push_back(b[k]);
    if (stall > 0) begin
      repeat (stall) @(posedge clk);
      #1 tx_full = 1'b0;
      @(negedge clk);
      check("wr_on_release", wr_uart, 1'b1);
    end
    wait_writes(wr0 + 2);
    if (poke) begin
      @(posedge clk); #1;
      cmd_valid = 1'b1;
      cmd_instr = ~instr;
      repeat (5) begin
        @(negedge clk);
        check("cmd_ready_in_rx", cmd_ready, 1'b0);
      end
      @(posedge clk); #1 cmd_valid = 1'b0;
    end
    if (gap > 0) begin
      for (int k = 0; k < 4; k++) begin
        repeat (gap) @(posedge clk);
        #1 rx_q.push_back(b[k]);
      end
    end
    for (int i = 0; i < 600 && exp_rsp.size() > 0; i++) @(negedge clk);
    check("rsp_seen", exp_rsp.size(), 0);
    @(negedge clk);
    check("cmd_ready_after", cmd_ready, 1'b1);
    check("rsp_acc_hold", rsp_acc, e.acc);
    check("rsp_pc_hold", rsp_pc, e.pc);
    check("wr_per_txn", wr_cnt - wr0, 2);
    check("rd_per_txn", rd_cnt - rd0, 4);
    last_acc = e.acc;
    last_pc  = e.pc;
  endtask

  task automatic reset_mid_frame();
    logic [15:0] instr;
    int rd0;
    instr = 16'($urandom);
    wait_ready();
    rd0 = rd_cnt;
    exp_tx.push_back(instr[7:0]);
    exp_tx.push_back(instr[15:8]);
    issue(instr, 1'b0);
    wait_writes(wr_cnt + (exp_tx.size() > 0 ? 1 : 0));
    for (int i = 0; i < 100 && exp_tx.size() > 0; i++) @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      repeat (20) @(posedge clk);
      #1 rx_q.push_back(8'(k + 8'h71));
    end
    for (int i = 0; i < 100 && rd_cnt < rd0 + 2; i++) @(negedge clk);
    check("rd_before_reset", rd_cnt - rd0, 2);
    @(posedge clk); #2;
    reset = 1'b0;
    rx_q.delete();
    @(negedge clk);
    check("abort_cmd_ready", cmd_ready, 1'b1);
    check("abort_rsp_acc", rsp_acc, 16'h0000);
    check("abort_rsp_pc", rsp_pc, 11'h000);
    check("abort_rd_uart", rd_uart, 1'b0);
    @(posedge clk); #2 reset = 1'b1;
    last_acc = '0;
    last_pc  = '0;
  endtask

  initial begin
    #(PERIOD * 50000);
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1);
  end

  initial begin
    @(negedge clk);
    check("rst_cmd_ready", cmd_ready, 1'b1);
    check("rst_wr_uart", wr_uart, 1'b0);
    check("rst_rd_uart", rd_uart, 1'b0);
    check("rst_rsp_valid", rsp_valid, 1'b0);
    check("rst_rsp_err", rsp_err, 1'b0);
    check("rst_w_data", w_data, 8'h00);
    check("rst_rsp_acc", rsp_acc, 16'h0000);
    check("rst_rsp_pc", rsp_pc, 11'h000);
    @(posedge clk); #2 reset = 1'b1;

    txn(16'h1805, 32'h0007_1234, 0, 0, 1'b0);
    check("t1_acc", rsp_acc, 16'h1234);
    check("t1_pc", rsp_pc, 11'h007);
    txn(16'h1805, 32'h0312_A50F, 1, 10, 1'b0);
    txn(16'hBEEF, 32'hFF3C_55AA, 50, 0, 1'b0);
    check("pc_upper_bits", rsp_pc[10:8], 3'b111);
    txn(16'h0F0F, 32'h0456_789A, 3, 0, 1'b1);
    reset_mid_frame();
    txn(16'h2A51, 32'h05C3_9E01, 2, 1, 1'b0);

    for (int t = 0; t < 16; t++) begin
      int gap;
      gap = int'($urandom_range(0, 6));
      txn(16'($urandom), $urandom, gap, int'($urandom_range(0, 3)),
          (gap > 0) && ($urandom_range(0, 3) == 0));
    end

`ifdef BIP_HOST_TIMEOUT_EN
    begin
      logic [15:0] instr;
      instr = 16'h6C3D;
      wait_ready();
      exp_err = 1;
      exp_tx.push_back(instr[7:0]);
      exp_tx.push_back(instr[15:8]);
      issue(instr, 1'b0);
      for (int i = 0; i < 100 && exp_tx.size() > 0; i++) @(negedge clk);
      check("to_writes_done", exp_tx.size(), 0);
      for (int i = 0; i < 300 && err_cnt < 1; i++) @(negedge clk);
      check("to_err_seen", err_cnt, 1);
      check("to_err_latency", 32'((err_time - wr_time) / PERIOD), 101);
      @(negedge clk);
      check("to_cmd_ready", cmd_ready, 1'b1);
      check("to_rsp_acc_kept", rsp_acc, last_acc);
      check("to_rsp_pc_kept", rsp_pc, last_pc);
    end
`endif

    repeat (5) @(negedge clk);
    check("tx_queue_empty", exp_tx.size(), 0);
    check("rsp_queue_empty", exp_rsp.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
